// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the MIPS32 execute-stage ALU.
//   ALUOP_*  : 2-bit ALUop encodings from the main control unit
//   F_* / OP_*: funct (R-type) and opcode (I-type) field values
//   C_*      : 4-bit ALU control codes
//   state_t  : multi-cycle FSM state encoding
//   alu_decode / alu_ovf_en: pure decode helpers
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [3:0] C_AND   = 4'b0000;
  localparam logic [3:0] C_OR    = 4'b0001;
  localparam logic [3:0] C_ADD   = 4'b0010;
  localparam logic [3:0] C_XOR   = 4'b0011;
  localparam logic [3:0] C_DIVU  = 4'b0100;
  localparam logic [3:0] C_SUB   = 4'b0110;
  localparam logic [3:0] C_SLT   = 4'b0111;
  localparam logic [3:0] C_SLTU  = 4'b1000;
  localparam logic [3:0] C_MFHI  = 4'b1001;
  localparam logic [3:0] C_MFLO  = 4'b1010;
  localparam logic [3:0] C_NOR   = 4'b1100;
  localparam logic [3:0] C_MULT  = 4'b1101;
  localparam logic [3:0] C_MULTU = 4'b1110;
  localparam logic [3:0] C_DIV   = 4'b1111;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

  function automatic logic [3:0] alu_decode(input logic [1:0] aluop, input logic [5:0] fnc);
    logic [3:0] code;
    code = C_ADD;
    case (aluop)
      ALUOP_ADD: code = C_ADD;
      ALUOP_SUB: code = C_SUB;
      ALUOP_RTYPE: begin
        case (fnc)
          F_ADD:   code = C_ADD;
          F_SUB:   code = C_SUB;
          F_AND:   code = C_AND;
          F_OR:    code = C_OR;
          F_XOR:   code = C_XOR;
          F_NOR:   code = C_NOR;
          F_SLT:   code = C_SLT;
          F_SLTU:  code = C_SLTU;
          F_MFHI:  code = C_MFHI;
          F_MFLO:  code = C_MFLO;
          F_MULT:  code = C_MULT;
          F_MULTU: code = C_MULTU;
          F_DIV:   code = C_DIV;
          F_DIVU:  code = C_DIVU;
          default: code = C_ADD;
        endcase
      end
      default: begin
        case (fnc)
          OP_ADDI: code = C_ADD;
          OP_ANDI: code = C_AND;
          OP_ORI:  code = C_OR;
          OP_XORI: code = C_XOR;
          OP_SLTI: code = C_SLT;
          default: code = C_ADD;
        endcase
      end
    endcase
    return code;
  endfunction

  // Overflow is reported only for the trapping instructions ADD, SUB and ADDI.
  function automatic logic alu_ovf_en(input logic [1:0] aluop, input logic [5:0] fnc);
    return ((aluop == ALUOP_RTYPE) && ((fnc == F_ADD) || (fnc == F_SUB))) ||
           ((aluop == ALUOP_ITYPE) && (fnc == OP_ADDI));
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: unsigned iterative multiply (shift-add) / restoring divide.
//   load     in : capture op_a/op_b magnitudes and start WIDTH iterations
//   mode_div in : 1 = divide (op_a / op_b), 0 = multiply (op_a * op_b)
//   busy     out: iterations remaining
//   fin      out: the coming edge performs the last iteration
//   hi_mag/lo_mag out: product {hi,lo}, or remainder/quotient for divide
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] hi_mag,
  output logic [WIDTH-1:0] lo_mag
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q;
  logic             mode_q;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q;
  logic [WIDTH:0]   msum, partial, trial;

  assign busy   = (cnt_q != '0);
  assign fin    = (cnt_q == CW'(1));
  assign hi_mag = acc_hi_q;
  assign lo_mag = acc_lo_q;

  // Both modes share acc_hi (partial product / remainder) and acc_lo
  // (multiplier shifting out / dividend shifting out, quotient shifting in).
  always_comb begin
    msum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    partial  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    trial    = partial - {1'b0, opb_q};
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    if (mode_q) begin
      if (!trial[WIDTH]) begin
        acc_hi_d = trial[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_d = partial[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_hi_d = msum[WIDTH:1];
      acc_lo_d = {msum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
    end else if (load) begin
      cnt_q    <= CW'(WIDTH);
      mode_q   <= mode_div;
      acc_hi_q <= '0;
      acc_lo_q <= op_a;
      opb_q    <= op_b;
    end else if (busy) begin
      cnt_q    <= cnt_q - CW'(1);
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
    end
  end

endmodule

// File: rtl/alu_exec_multiciclo.sv
// alu_exec_multiciclo: MIPS32 EX-stage ALU control, single-cycle ALU and
// multi-cycle MULT/MULTU/DIV/DIVU with HI/LO.
//   clk, rst (async, active-high); start/ready/done handshake
//   ALUop, instruccion_FNC: operation select; a, b: operands
//   result, zero, ovf: registered result and flags (valid with done)
//   sal_alu_control: control code of last accepted op; hi, lo: HI/LO registers
module alu_exec_multiciclo
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FNC_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       ALUop,
  input  logic [FNC_W-1:0] instruccion_FNC,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic [3:0]       sal_alu_control,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t           state_q, state_d;
  logic [3:0]       dec_code, ctrl_q, ctrl_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d, a_q, a_d;
  logic             ovf_q, ovf_d, done_q, done_d, div0_q, div0_d, mul_q, mul_d;
  logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] sum, diff, alu_res, mag_a, mag_b, it_hi, it_lo;
  logic [2*WIDTH-1:0] prod_mag;
  logic             alu_ovf, ovf_en, is_mul, is_div, is_signed;
  logic             it_load, it_busy, it_fin;

  assign dec_code  = alu_decode(ALUop, 6'(instruccion_FNC));
  assign ovf_en    = alu_ovf_en(ALUop, 6'(instruccion_FNC));
  assign is_mul    = (dec_code == C_MULT) || (dec_code == C_MULTU);
  assign is_div    = (dec_code == C_DIV)  || (dec_code == C_DIVU);
  assign is_signed = (dec_code == C_MULT) || (dec_code == C_DIV);
  assign mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
  assign prod_mag  = {it_hi, it_lo};

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    alu_res = sum;
    alu_ovf = 1'b0;
    case (dec_code)
      C_AND:  alu_res = a & b;
      C_OR:   alu_res = a | b;
      C_XOR:  alu_res = a ^ b;
      C_NOR:  alu_res = ~(a | b);
      C_SUB:  alu_res = diff;
      C_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      C_SLTU: alu_res = WIDTH'(a < b);
      C_MFHI: alu_res = hi_q;
      C_MFLO: alu_res = lo_q;
      default: alu_res = sum;
    endcase
    if (ovf_en) begin
      if (dec_code == C_SUB)
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      else
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (it_load),
    .mode_div (is_div),
    .op_a     (mag_a),
    .op_b     (mag_b),
    .busy     (it_busy),
    .fin      (it_fin),
    .hi_mag   (it_hi),
    .lo_mag   (it_lo)
  );

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    a_d      = a_q;
    div0_d   = div0_q;
    mul_d    = mul_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    it_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ctrl_d = dec_code;
          if (is_mul) begin
            it_load  = 1'b1;
            mul_d    = 1'b1;
            div0_d   = 1'b0;
            neg_lo_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            state_d  = ST_MUL;
          end else if (is_div) begin
            mul_d    = 1'b0;
            a_d      = a;
            neg_lo_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi_d = is_signed && a[WIDTH-1];
            if (b == '0) begin
              div0_d  = 1'b1;
              state_d = ST_FIX;
            end else begin
              div0_d  = 1'b0;
              it_load = 1'b1;
              state_d = ST_DIV;
            end
          end else begin
            result_d = alu_res;
            ovf_d    = alu_ovf;
            done_d   = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (it_fin || !it_busy) state_d = ST_FIX;
      end
      default: begin
        // Quotient truncates toward zero; remainder follows the dividend sign.
        if (div0_q) begin
          lo_d = '1;
          hi_d = a_q;
        end else if (mul_q) begin
          {hi_d, lo_d} = neg_lo_q ? -prod_mag : prod_mag;
        end else begin
          lo_d = neg_lo_q ? -it_lo : it_lo;
          hi_d = neg_hi_q ? -it_hi : it_hi;
        end
        result_d = lo_d;
        ovf_d    = 1'b0;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= C_ADD;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      div0_q   <= 1'b0;
      mul_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      a_q      <= a_d;
      div0_q   <= div0_d;
      mul_q    <= mul_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

  assign ready           = (state_q == ST_IDLE);
  assign done            = done_q;
  assign result          = result_q;
  assign zero            = (result_q == '0);
  assign ovf             = ovf_q;
  assign sal_alu_control = ctrl_q;
  assign hi              = hi_q;
  assign lo              = lo_q;

endmodule
